snake_body_ctrl: RTL and testbench
==================================

# snake_body_ctrl

Sequencer for the snake body stack: on each game tick it computes the new head cell from the player direction, then drives the stack's push or pop strobe, presenting the new head coordinates. It then walks the stack through its read strobe to detect self-collision, and raises `game_over` on wall or body hit. It sits between the game-tick/joystick logic and the body stack, and is the only agent allowed to drive the stack strobes.

## Interface
Parameters:
- `DEPTH`, 501: stack entries; read index wraps after DEPTH reads.
- `STEP`, 10: head displacement per tick, in pixels.
- `X_MAX`, 630: largest legal head X (inclusive); smallest is 0.
- `Y_MAX`, 470: largest legal head Y (inclusive); smallest is 0.
- `START_X`, 320: head X after reset.
- `START_Y`, 240: head Y after reset.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle game-step strobe.
- `dir` in 2: requested direction; 0=up, 1=right, 2=down, 3=left.
- `grow` in 1: sampled with an accepted tick; 1 = lengthen by one.
- `stk_push` out 1: stack push strobe.
- `stk_pop` out 1: stack pop strobe.
- `stk_obtener` out 1: stack read strobe.
- `stk_wx` out 12: X written to stack.
- `stk_wy` out 12: Y written to stack.
- `stk_rx` in 12: X read data; valid the cycle after `stk_obtener`.
- `stk_ry` in 12: Y read data; valid the cycle after `stk_obtener`.
- `head_x` out 12: current head X.
- `head_y` out 12: current head Y.
- `length` out 10: body length.
- `busy` out 1: high in every state except IDLE and OVER.
- `step_done` out 1: one-cycle pulse when a step completes.
- `game_over` out 1: sticky until reset.

## Operation
- States: INIT, IDLE, MOVE, SCAN, DRAIN, DONE, OVER.
- Reset values:
  - State = INIT; `head_x`=START_X, `head_y`=START_Y, `length`=0.
  - `cur_dir`=1 (right).
  - All strobes 0; `step_done`=0, `game_over`=0.
  - `stk_wx`=START_X, `stk_wy`=START_Y.
- INIT: one cycle with `stk_push`=1 and `stk_wx/wy`=start position; `length`←1; go to IDLE.
- IDLE:
  - `tick`=1 latches `grow`.
  - Updates `cur_dir`←`dir` unless `dir` is the opposite of `cur_dir`; opposite requests are ignored.
  - Computes the candidate head (`cur_dir` applied, ±STEP).
  - Wall check in 13-bit signed arithmetic. Hit if X<0, X>X_MAX, Y<0 or Y>Y_MAX.
  - Hit → OVER with no stack strobe. Otherwise → MOVE.
- MOVE: one cycle.
  - `stk_wx/wy`=candidate; `head_x/y`←candidate.
  - Grow: `stk_push`=1 and `length`←`length`+1, saturating at DEPTH−1. At saturation, pop is used instead of push.
  - No grow: `stk_pop`=1, `length` unchanged.
  - → SCAN.
- SCAN:
  - `stk_obtener`=1 for exactly DEPTH consecutive cycles, counted 0..DEPTH−1. This keeps the stack read index aligned across steps.
  - Read sample k arrives one cycle after strobe k.
  - Samples k < `length`−1 are compared with `head_x/y`; any equality sets the internal `hit` flag.
  - Samples k ≥ `length`−1 are ignored.
  - After the last strobe → DRAIN.
- DRAIN: one cycle to compare the final sample; → DONE.
- DONE:
  - `step_done`=1 for one cycle.
  - `hit`=1 → OVER, else → IDLE.
  - `hit` is cleared on entry to MOVE.
- OVER:
  - `game_over`=1; no strobes.
  - Ticks are ignored; only `reset` exits.
- At most one of `stk_push`, `stk_pop`, `stk_obtener` is high in any cycle.

## Timing
- Reset mid-step: the next edge enters INIT regardless of state. Strobes drop the same cycle; the stack is reset by the same `reset`.
- Tick latency:
  - Tick accepted in IDLE at cycle t → MOVE strobe at t+1.
  - `stk_obtener` at t+2 .. t+DEPTH+1.
  - `step_done` at t+DEPTH+3.
- Ticks arriving while `busy`=1 are dropped, not queued.
- `tick` and `reset` together: reset wins.
- Wall hit: `game_over` rises at t+1; no `step_done` pulse.
- `dir` is sampled only with an accepted tick.

## Configuration
- `SNAKE_SELF_COLLISION_EN` defined: behaviour as above.
- Not defined:
  - SCAN and DRAIN are removed; MOVE → DONE directly.
  - `stk_obtener` is tied 0 and `hit` is constant 0.
  - Only wall hits cause OVER.
  - `step_done` comes at t+2.

## Test plan
- Reset, then idle 5 cycles → one `stk_push` with (320,240); `length`=1, `busy`=0, `head`=(320,240).
- Tick, `dir`=1, `grow`=0 → `stk_pop` with (330,240) at t+1; 501 `stk_obtener` strobes; `step_done` at t+504; `length`=1.
- Tick with `grow`=1 three times → three `stk_push` strobes at (330,240), (340,240), (350,240); `length`=4; no `game_over`.
- Head at (320,240) moving right; tick with `dir`=3 → `dir` is ignored; head becomes (330,240).
- Head at (630,100) moving right; tick → `game_over` at t+1, no strobes, no `step_done`; later ticks ignored until `reset`.
- Bench model returns a read sample with k=0 equal to the new head, `length`=5 → `step_done` pulse, then `game_over`=1. With `SNAKE_SELF_COLLISION_EN` undefined: no `stk_obtener` and no `game_over`.

Source files
------------

// File: rtl/snake_body_ctrl_if.sv
// snake_body_ctrl_if: strobe and data bus between the snake body sequencer and the body stack.
// The sequencer is the master and the only agent that drives the stack strobes.
interface snake_body_ctrl_if;
    logic        push;
    logic        pop;
    logic        obtener;
    logic [11:0] wx;
    logic [11:0] wy;
    logic [11:0] rx;
    logic [11:0] ry;

    modport master (output push, pop, obtener, wx, wy, input rx, ry);
    modport slave  (input push, pop, obtener, wx, wy, output rx, ry);
endinterface

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: per-tick sequencer that moves the head, pushes/pops the body stack and ends the game on a hit.
// Define SNAKE_SELF_COLLISION_EN to build the DEPTH-read self-collision scan; otherwise only walls end the game.
module snake_body_ctrl #(
    parameter int DEPTH   = 501,
    parameter int STEP    = 10,
    parameter int X_MAX   = 630,
    parameter int Y_MAX   = 470,
    parameter int START_X = 320,
    parameter int START_Y = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_i,
    input  logic [1:0]         dir_i,
    input  logic               grow_i,
    snake_body_ctrl_if.master  stk,
    output logic [11:0]        head_x_o,
    output logic [11:0]        head_y_o,
    output logic [9:0]         length_o,
    output logic               busy_o,
    output logic               step_done_o,
    output logic               game_over_o
);
    localparam int                 CW      = $clog2(DEPTH);
    localparam logic signed [12:0] STEP_S  = 13'(STEP);
    localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
    localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
    localparam logic [9:0]         LEN_MAX = 10'(DEPTH - 1);

    typedef enum logic [2:0] {INIT, IDLE, MOVE, SCAN, DRAIN, DONE, OVER} state_t;

    state_t             state_q;
    logic [11:0]        head_x_q, head_y_q;
    logic [11:0]        wx_q, wy_q;
    logic [9:0]         length_q;
    logic [1:0]         cur_dir_q, dir_d;
    logic               push_q, pop_q, step_done_q, game_over_q;
    logic signed [12:0] cand_x_d, cand_y_d;
    logic               wall_hit_d;
`ifdef SNAKE_SELF_COLLISION_EN
    logic               obt_q, hit_q, smp_vld_q;
    logic [CW-1:0]      cnt_q, smp_idx_q;
`endif

    // Directions 0/2 and 1/3 are opposites, so a reversal differs from cur_dir only in bit 1.
    always_comb begin
        dir_d = cur_dir_q;
        if (dir_i != (cur_dir_q ^ 2'd2))
            dir_d = dir_i;
        cand_x_d = $signed({1'b0, head_x_q});
        cand_y_d = $signed({1'b0, head_y_q});
        case (dir_d)
            2'd0:    cand_y_d = cand_y_d - STEP_S;
            2'd1:    cand_x_d = cand_x_d + STEP_S;
            2'd2:    cand_y_d = cand_y_d + STEP_S;
            default: cand_x_d = cand_x_d - STEP_S;
        endcase
        wall_hit_d = (cand_x_d < 0) || (cand_x_d > X_MAX_S) ||
                     (cand_y_d < 0) || (cand_y_d > Y_MAX_S);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            head_x_q    <= 12'(START_X);
            head_y_q    <= 12'(START_Y);
            wx_q        <= 12'(START_X);
            wy_q        <= 12'(START_Y);
            length_q    <= '0;
            cur_dir_q   <= 2'd1;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            step_done_q <= 1'b0;
            game_over_q <= 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
            obt_q       <= 1'b0;
            hit_q       <= 1'b0;
            smp_vld_q   <= 1'b0;
            cnt_q       <= '0;
            smp_idx_q   <= '0;
`endif
        end else begin
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            step_done_q <= 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
            // Read data trails its strobe by one cycle; only the body behind the head is compared.
            smp_vld_q <= obt_q;
            smp_idx_q <= cnt_q;
            if (smp_vld_q && (10'(smp_idx_q) < length_q - 10'd1) &&
                stk.rx == head_x_q && stk.ry == head_y_q)
                hit_q <= 1'b1;
`endif
            case (state_q)
                INIT: begin
                    length_q <= 10'd1;
                    state_q  <= IDLE;
                end
                IDLE: begin
                    if (tick_i) begin
                        cur_dir_q <= dir_d;
                        if (wall_hit_d) begin
                            game_over_q <= 1'b1;
                            state_q     <= OVER;
                        end else begin
                            head_x_q <= cand_x_d[11:0];
                            head_y_q <= cand_y_d[11:0];
                            wx_q     <= cand_x_d[11:0];
                            wy_q     <= cand_y_d[11:0];
                            if (grow_i && length_q != LEN_MAX) begin
                                push_q   <= 1'b1;
                                length_q <= length_q + 10'd1;
                            end else begin
                                pop_q <= 1'b1;
                            end
`ifdef SNAKE_SELF_COLLISION_EN
                            hit_q <= 1'b0;
`endif
                            state_q <= MOVE;
                        end
                    end
                end
                MOVE: begin
`ifdef SNAKE_SELF_COLLISION_EN
                    obt_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= SCAN;
`else
                    step_done_q <= 1'b1;
                    state_q     <= DONE;
`endif
                end
`ifdef SNAKE_SELF_COLLISION_EN
                SCAN: begin
                    if (cnt_q == CW'(DEPTH - 1)) begin
                        obt_q   <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    step_done_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (hit_q) begin
                        game_over_q <= 1'b1;
                        state_q     <= OVER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
`else
                DONE: state_q <= IDLE;
`endif
                OVER:    game_over_q <= 1'b1;
                default: state_q <= INIT;
            endcase
        end
    end

    // The INIT push is gated by reset so every strobe stays low while reset is held.
    assign stk.push    = push_q | (state_q == INIT && !reset);
    assign stk.pop     = pop_q;
`ifdef SNAKE_SELF_COLLISION_EN
    assign stk.obtener = obt_q;
`else
    assign stk.obtener = 1'b0;
`endif
    assign stk.wx      = wx_q;
    assign stk.wy      = wy_q;

    assign head_x_o    = head_x_q;
    assign head_y_o    = head_y_q;
    assign length_o    = length_q;
    assign busy_o      = (state_q != IDLE) && (state_q != OVER);
    assign step_done_o = step_done_q;
    assign game_over_o = game_over_q;
endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl: randomized bench for snake_body_ctrl with a coordinate-level snake model and a scripted stack.
// Expectations follow SNAKE_SELF_COLLISION_EN when it is defined for the build.
module tb_snake_body_ctrl;
    localparam int DEPTH   = 501;
    localparam int STEP    = 10;
    localparam int X_MAX   = 630;
    localparam int Y_MAX   = 470;
    localparam int START_X = 320;
    localparam int START_Y = 240;
`ifdef SNAKE_SELF_COLLISION_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        tick;
    logic [1:0]  dir;
    logic        grow;
    logic [11:0] headX, headY;
    logic [9:0]  length;
    logic        busy, stepDone, gameOver;

    snake_body_ctrl_if stk ();

    snake_body_ctrl #(
        .DEPTH(DEPTH), .STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .clk(clk), .reset(reset), .tick_i(tick), .dir_i(dir), .grow_i(grow),
        .stk(stk), .head_x_o(headX), .head_y_o(headY), .length_o(length),
        .busy_o(busy), .step_done_o(stepDone), .game_over_o(gameOver)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Observations collected each cycle on the falling edge
    int pushCnt, popCnt, obtCnt, obtFirst, doneCnt, doneCyc, goCyc, strobeCyc;
    int exclCnt = 0;
    logic [11:0] strobeX, strobeY;

    // Scripted stack: read k of each scan returns rdX/rdY[k]
    logic [11:0] rdX [DEPTH];
    logic [11:0] rdY [DEPTH];
    int ridx;

    // Coordinate-level snake model
    int mX, mY, mDir, mLen;
    bit mOver;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            ridx <= 0;
        end else if (stk.obtener) begin
            stk.rx <= rdX[ridx];
            stk.ry <= rdY[ridx];
            ridx   <= (ridx == DEPTH - 1) ? 0 : ridx + 1;
        end
    end

    always @(negedge clk) begin
        if (stk.push) begin pushCnt++; strobeCyc = cyc; strobeX = stk.wx; strobeY = stk.wy; end
        if (stk.pop)  begin popCnt++;  strobeCyc = cyc; strobeX = stk.wx; strobeY = stk.wy; end
        if (stk.obtener) begin
            if (obtCnt == 0) obtFirst = cyc;
            obtCnt++;
        end
        if (int'(stk.push) + int'(stk.pop) + int'(stk.obtener) > 1) exclCnt++;
        if (stepDone) begin
            if (doneCnt == 0) doneCyc = cyc;
            doneCnt++;
        end
        if (gameOver && goCyc < 0) goCyc = cyc;
    end

    task automatic clear_obs();
        pushCnt = 0; popCnt = 0; obtCnt = 0; obtFirst = -1;
        doneCnt = 0; doneCyc = -1; goCyc = -1; strobeCyc = -1;
    endtask

    task automatic model_init();
        mX = START_X; mY = START_Y; mDir = 1; mLen = 1; mOver = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin rdX[i] = 12'd5; rdY[i] = 12'd5; end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        model_init();
    endtask

    // One game tick: predict from the model, drive it, then compare everything observed.
    task automatic run_step(input logic [1:0] d, input logic g, input int plantK);
        int nd, nx, ny, nlen, t;
        bit wasOver, wall, expPush, col, busyMid;
        wasOver = mOver;
        nd = mDir;
        if (int'(d) != (mDir + 2) % 4) nd = int'(d);
        nx = mX; ny = mY;
        case (nd)
            0:       ny = ny - STEP;
            1:       nx = nx + STEP;
            2:       ny = ny + STEP;
            default: nx = nx - STEP;
        endcase
        wall = (nx < 0) || (nx > X_MAX) || (ny < 0) || (ny > Y_MAX);
        expPush = g && (mLen < DEPTH - 1);
        nlen = expPush ? mLen + 1 : mLen;
        if (plantK >= 0 && !wall && !wasOver) begin
            rdX[plantK] = 12'(nx); rdY[plantK] = 12'(ny);
        end
        col = 1'b0;
        if (SCAN_EN)
            for (int i = 0; i < nlen - 1; i++)
                if (rdX[i] == 12'(nx) && rdY[i] == 12'(ny)) col = 1'b1;

        @(posedge clk); #1;
        clear_obs();
        t = cyc;
        tick = 1'b1; dir = d; grow = g;
        @(posedge clk); #1;
        tick = 1'b0;
        busyMid = busy;
        for (int i = 0; i < DEPTH + 10; i++) begin
            if (doneCnt > 0 || gameOver) break;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;

        if (wasOver || wall) begin
            checks++; if (pushCnt + popCnt + obtCnt !== 0) begin errors++; $display("[TB] FAIL no_strobe: got %0d strobes want 0", pushCnt + popCnt + obtCnt); end
            checks++; if (doneCnt !== 0) begin errors++; $display("[TB] FAIL no_done: got %0d pulses want 0", doneCnt); end
            checks++; if (gameOver !== 1'b1) begin errors++; $display("[TB] FAIL over_flag: got %b want 1", gameOver); end
            checks++; if (headX !== 12'(mX) || headY !== 12'(mY)) begin errors++; $display("[TB] FAIL head_hold: got (%0d,%0d) want (%0d,%0d)", headX, headY, mX, mY); end
            if (!wasOver) begin
                checks++; if (goCyc !== t + 1) begin errors++; $display("[TB] FAIL wall_latency: got cycle %0d want %0d", goCyc, t + 1); end
            end
        end else begin
            checks++; if (pushCnt !== int'(expPush) || popCnt !== int'(!expPush)) begin errors++; $display("[TB] FAIL strobe_kind: got push=%0d pop=%0d want push=%0d pop=%0d", pushCnt, popCnt, expPush, !expPush); end
            checks++; if (strobeCyc !== t + 1) begin errors++; $display("[TB] FAIL strobe_cycle: got %0d want %0d", strobeCyc, t + 1); end
            checks++; if (strobeX !== 12'(nx) || strobeY !== 12'(ny)) begin errors++; $display("[TB] FAIL strobe_xy: got (%0d,%0d) want (%0d,%0d)", strobeX, strobeY, nx, ny); end
            checks++; if (busyMid !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid: got %b want 1", busyMid); end
            checks++; if (obtCnt !== (SCAN_EN ? DEPTH : 0)) begin errors++; $display("[TB] FAIL read_count: got %0d want %0d", obtCnt, SCAN_EN ? DEPTH : 0); end
            checks++; if (obtFirst !== (SCAN_EN ? t + 2 : -1)) begin errors++; $display("[TB] FAIL read_start: got %0d want %0d", obtFirst, SCAN_EN ? t + 2 : -1); end
            checks++; if (doneCnt !== 1 || doneCyc !== (SCAN_EN ? t + DEPTH + 3 : t + 2)) begin errors++; $display("[TB] FAIL step_done: got %0d pulses at %0d want 1 at %0d", doneCnt, doneCyc, SCAN_EN ? t + DEPTH + 3 : t + 2); end
            checks++; if (headX !== 12'(nx) || headY !== 12'(ny)) begin errors++; $display("[TB] FAIL head: got (%0d,%0d) want (%0d,%0d)", headX, headY, nx, ny); end
            checks++; if (length !== 10'(nlen)) begin errors++; $display("[TB] FAIL length: got %0d want %0d", length, nlen); end
            checks++; if (gameOver !== col) begin errors++; $display("[TB] FAIL collision: got %b want %b", gameOver, col); end
            checks++; if (goCyc !== (col ? t + DEPTH + 4 : -1)) begin errors++; $display("[TB] FAIL over_cycle: got %0d want %0d", goCyc, col ? t + DEPTH + 4 : -1); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after: got %b want 0", busy); end
        end

        if (!wasOver) begin
            if (wall) begin
                mOver = 1'b1;
            end else begin
                mDir = nd; mX = nx; mY = ny; mLen = nlen;
                if (col) mOver = 1'b1;
            end
        end
        if (plantK >= 0) begin rdX[plantK] = 12'd5; rdY[plantK] = 12'd5; end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1; tick = 1'b1; dir = 2'd0; grow = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (length !== 10'd0) begin errors++; $display("[TB] FAIL rst_length: got %0d want 0", length); end
        checks++; if ({stk.push, stk.pop, stk.obtener} !== 3'b000) begin errors++; $display("[TB] FAIL rst_strobes: got %b want 000", {stk.push, stk.pop, stk.obtener}); end
        checks++; if (headX !== 12'(START_X) || headY !== 12'(START_Y)) begin errors++; $display("[TB] FAIL rst_head: got (%0d,%0d) want (%0d,%0d)", headX, headY, START_X, START_Y); end
        checks++; if (stk.wx !== 12'(START_X) || stk.wy !== 12'(START_Y)) begin errors++; $display("[TB] FAIL rst_wxy: got (%0d,%0d) want (%0d,%0d)", stk.wx, stk.wy, START_X, START_Y); end
        checks++; if (stepDone !== 1'b0 || gameOver !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags: got done=%b over=%b want 0 0", stepDone, gameOver); end
        tick = 1'b0; grow = 1'b0;
        clear_obs();
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (pushCnt !== 1 || popCnt !== 0 || obtCnt !== 0) begin errors++; $display("[TB] FAIL init_push: got push=%0d pop=%0d rd=%0d want 1 0 0", pushCnt, popCnt, obtCnt); end
        checks++; if (strobeX !== 12'(START_X) || strobeY !== 12'(START_Y)) begin errors++; $display("[TB] FAIL init_xy: got (%0d,%0d) want (%0d,%0d)", strobeX, strobeY, START_X, START_Y); end
        checks++; if (length !== 10'd1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL init_state: got len=%0d busy=%b want 1 0", length, busy); end
        model_init();
    endtask

    task automatic test_midstep_reset();
        apply_reset();
        @(posedge clk); #1;
        tick = 1'b1; dir = 2'd1; grow = 1'b0;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        checks++; if ({stk.push, stk.pop, stk.obtener} !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_strobes: got %b want 000", {stk.push, stk.pop, stk.obtener}); end
        checks++; if (length !== 10'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_state: got len=%0d busy=%b want 0 1", length, busy); end
        tick = 1'b0;
        clear_obs();
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (pushCnt !== 1 || strobeX !== 12'(START_X) || headX !== 12'(START_X) || length !== 10'd1) begin errors++; $display("[TB] FAIL mid_rst_init: got push=%0d wx=%0d head_x=%0d len=%0d want 1 %0d %0d 1", pushCnt, strobeX, headX, length, START_X, START_X); end
        model_init();
    endtask

    task automatic test_move();
        apply_reset();
        run_step(2'd1, 1'b0, -1);
    endtask

    task automatic test_grow();
        apply_reset();
        for (int i = 0; i < 3; i++) run_step(2'd1, 1'b1, -1);
        checks++; if (length !== 10'd4 || headX !== 12'd350) begin errors++; $display("[TB] FAIL grow_total: got len=%0d x=%0d want 4 350", length, headX); end
    endtask

    task automatic test_reverse();
        apply_reset();
        run_step(2'd3, 1'b0, -1);
        checks++; if (headX !== 12'd330 || headY !== 12'd240) begin errors++; $display("[TB] FAIL reverse_head: got (%0d,%0d) want (330,240)", headX, headY); end
    endtask

    task automatic test_collision();
        apply_reset();
        for (int i = 0; i < 4; i++) run_step(2'd0, 1'b1, -1);
        run_step(2'd0, 1'b0, 4);
        run_step(2'd0, 1'b0, 3);
        apply_reset();
        for (int i = 0; i < 4; i++) run_step(2'd1, 1'b1, -1);
        run_step(2'd1, 1'b0, 0);
        checks++; if (gameOver !== SCAN_EN) begin errors++; $display("[TB] FAIL self_hit: got %b want %b", gameOver, SCAN_EN); end
    endtask

    task automatic test_wall(input logic [1:0] d);
        apply_reset();
        for (int i = 0; i < 60 && !mOver; i++) run_step(d, 1'b0, -1);
        checks++; if (gameOver !== 1'b1) begin errors++; $display("[TB] FAIL wall_reached: got %b want 1", gameOver); end
        run_step(2'd2, 1'b1, -1);
        run_step(2'd1, 1'b0, -1);
        apply_reset();
        checks++; if (gameOver !== 1'b0) begin errors++; $display("[TB] FAIL over_cleared: got %b want 0", gameOver); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            apply_reset();
            for (int i = 0; i < 10; i++) begin
                int k;
                k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, mLen)) : -1;
                run_step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), k);
            end
        end
    endtask

    task automatic test_exclusive();
        checks++; if (exclCnt !== 0) begin errors++; $display("[TB] FAIL strobe_exclusive: got %0d overlapping cycles want 0", exclCnt); end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; dir = 2'd1; grow = 1'b0;
        clear_obs();
        model_init();
        test_reset();
        test_midstep_reset();
        test_move();
        test_grow();
        test_reverse();
        test_collision();
        test_wall(2'd0);
        test_wall(2'd1);
        test_wall(2'd2);
        test_random();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
